// File: rtl/fuzzifier_dt.sv
// Three parallel trapezoid membership evaluators (NEG, ZERO, POS) for a signed
// dT sample, producing registered Q1.15 memberships with one cycle of latency.
module fuzzifier_dt (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] x,
    input  logic signed [7:0] a_neg,
    input  logic signed [7:0] b_neg,
    input  logic signed [7:0] c_neg,
    input  logic signed [7:0] d_neg,
    input  logic signed [7:0] a_zero,
    input  logic signed [7:0] b_zero,
    input  logic signed [7:0] c_zero,
    input  logic signed [7:0] d_zero,
    input  logic signed [7:0] a_pos,
    input  logic signed [7:0] b_pos,
    input  logic signed [7:0] c_pos,
    input  logic signed [7:0] d_pos,
    output logic [15:0]       mu_neg,
    output logic [15:0]       mu_zero,
    output logic [15:0]       mu_pos
);

    localparam logic [15:0] MU_ONE = 16'h7FFF;

    // Slope value: (diff << 15) / span, both differences taken as 9-bit
    // patterns and read as unsigned; a zero span divides by one instead.
    function automatic logic [15:0] slope(input logic [8:0] diff,
                                          input logic [8:0] span);
        logic [23:0] num;
        logic [23:0] den;
        logic [23:0] quo;
        num = {diff, 15'd0};
        den = (span == 9'd0) ? 24'd1 : {15'd0, span};
        quo = num / den;
        slope = (quo[15:0] > MU_ONE) ? MU_ONE : quo[15:0];
    endfunction

    function automatic logic [15:0] trapezoid(input logic signed [7:0] xv,
                                              input logic signed [7:0] a,
                                              input logic signed [7:0] b,
                                              input logic signed [7:0] c,
                                              input logic signed [7:0] d);
        logic [8:0] xs, as, bs, cs, ds;
        xs = {xv[7], xv};
        as = {a[7], a};
        bs = {b[7], b};
        cs = {c[7], c};
        ds = {d[7], d};
        // Priority order matters for unordered or degenerate breakpoints.
        if (xv <= a || xv >= d)
            trapezoid = 16'd0;
        else if (xv >= b && xv <= c)
            trapezoid = MU_ONE;
        else if (xv > a && xv < b)
            trapezoid = slope(xs - as, bs - as);
        else
            trapezoid = slope(ds - xs, ds - cs);
    endfunction

    logic [15:0] mu_neg_d,  mu_neg_q;
    logic [15:0] mu_zero_d, mu_zero_q;
    logic [15:0] mu_pos_d,  mu_pos_q;

    always_comb begin
        mu_neg_d  = trapezoid(x, a_neg,  b_neg,  c_neg,  d_neg);
        mu_zero_d = trapezoid(x, a_zero, b_zero, c_zero, d_zero);
        mu_pos_d  = trapezoid(x, a_pos,  b_pos,  c_pos,  d_pos);
    end

    // NOTE: non-blocking assignments so all three registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mu_neg_q  <= 16'd0;
            mu_zero_q <= 16'd0;
            mu_pos_q  <= 16'd0;
        end else begin
            mu_neg_q  <= mu_neg_d;
            mu_zero_q <= mu_zero_d;
            mu_pos_q  <= mu_pos_d;
        end
    end

    assign mu_neg  = mu_neg_q;
    assign mu_zero = mu_zero_q;
    assign mu_pos  = mu_pos_q;

endmodule

// File: tb/tb_fuzzifier_dt.sv
// Self-checking bench for fuzzifier_dt: directed corner cases plus randomized
// breakpoints and samples compared against an arithmetic reference model.
module tb_fuzzifier_dt;

    logic              clk;
    logic              rst;
    logic signed [7:0] x;
    logic signed [7:0] a_neg, b_neg, c_neg, d_neg;
    logic signed [7:0] a_zero, b_zero, c_zero, d_zero;
    logic signed [7:0] a_pos, b_pos, c_pos, d_pos;
    logic [15:0]       mu_neg, mu_zero, mu_pos;

    int n_checks = 0;
    int n_pass   = 0;

    fuzzifier_dt dut (
        .clk(clk), .rst(rst), .x(x),
        .a_neg(a_neg), .b_neg(b_neg), .c_neg(c_neg), .d_neg(d_neg),
        .a_zero(a_zero), .b_zero(b_zero), .c_zero(c_zero), .d_zero(d_zero),
        .a_pos(a_pos), .b_pos(b_pos), .c_pos(c_pos), .d_pos(d_pos),
        .mu_neg(mu_neg), .mu_zero(mu_zero), .mu_pos(mu_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: membership from the rule list with plain integer arithmetic.
    function automatic int ratio(input int num_diff, input int span);
        int num, den, q;
        num = (num_diff & 511) * 32768;
        den = span & 511;
        if (den == 0) den = 1;
        q = (num / den) & 65535;
        return (q > 32767) ? 32767 : q;
    endfunction

    function automatic int model(input int xv, input int a, input int b,
                                 input int c, input int d);
        if (xv <= a || xv >= d) return 0;
        if (b <= xv && xv <= c) return 32767;
        if (a < xv && xv < b)   return ratio(xv - a, b - a);
        return ratio(d - xv, d - c);
    endfunction

    task automatic set_defaults();
        a_neg  = -100; b_neg  = -50; c_neg  = -30; d_neg  = -5;
        a_zero = -10;  b_zero = 0;   c_zero = 0;   d_zero = 10;
        a_pos  = 5;    b_pos  = 25;  c_pos  = 35;  d_pos  = 60;
    endtask

    // Drive x away from the edge, then sample just after the next rising edge.
    task automatic step(input int xv);
        @(negedge clk);
        x = 8'(xv);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_model(input string tag);
        check({tag, "_neg"},  int'(mu_neg),  model(int'(x), int'(a_neg),  int'(b_neg),  int'(c_neg),  int'(d_neg)));
        check({tag, "_zero"}, int'(mu_zero), model(int'(x), int'(a_zero), int'(b_zero), int'(c_zero), int'(d_zero)));
        check({tag, "_pos"},  int'(mu_pos),  model(int'(x), int'(a_pos),  int'(b_pos),  int'(c_pos),  int'(d_pos)));
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        int v[4];
        int t;
        rst = 1'b1;
        x   = 8'sd0;
        set_defaults();
        #1;
        check("reset_neg",  int'(mu_neg),  0);
        check("reset_zero", int'(mu_zero), 0);
        check("reset_pos",  int'(mu_pos),  0);
        @(negedge clk);
        rst = 1'b0;

        step(-128);
        check("xmin_neg", int'(mu_neg), 0);
        check("xmin_zero", int'(mu_zero), 0);
        check("xmin_pos", int'(mu_pos), 0);
        step(127);
        check("xmax_neg", int'(mu_neg), 0);
        check("xmax_zero", int'(mu_zero), 0);
        check("xmax_pos", int'(mu_pos), 0);

        step(0);
        check("x0_zero", int'(mu_zero), 32767);
        check("x0_neg", int'(mu_neg), 0);
        check("x0_pos", int'(mu_pos), 0);

        step(-5);
        check("xm5_zero", int'(mu_zero), 16384);
        check("xm5_neg", int'(mu_neg), 0);
        step(16);
        check("x16_pos", int'(mu_pos), 18022);
        step(49);
        check("x49_pos", int'(mu_pos), 14417);
        step(-38);
        check("xm38_neg", int'(mu_neg), 32767);
        step(-60);
        check("xm60_neg", int'(mu_neg), 26214);

        // Asynchronous reset mid-cycle, well before the next rising edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_neg", int'(mu_neg), 0);
        check("async_rst_zero", int'(mu_zero), 0);
        check("async_rst_pos", int'(mu_pos), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_neg", int'(mu_neg), 26214);

        a_pos = 20; b_pos = 20; c_pos = 20; d_pos = 20;
        step(20);
        check("point20_pos", int'(mu_pos), 0);
        step(19);
        check("point19_pos", int'(mu_pos), 0);
        set_defaults();

        // Ordered random breakpoints, then a batch with no ordering at all.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                for (int k = 0; k < 4; k++) v[k] = rnd8();
                if (i < 200) begin
                    for (int p = 0; p < 3; p++)
                        for (int q = 0; q < 3 - p; q++)
                            if (v[q] > v[q+1]) begin
                                t = v[q]; v[q] = v[q+1]; v[q+1] = t;
                            end
                end
                case (s)
                    0: begin a_neg = 8'(v[0]);  b_neg = 8'(v[1]);  c_neg = 8'(v[2]);  d_neg = 8'(v[3]);  end
                    1: begin a_zero = 8'(v[0]); b_zero = 8'(v[1]); c_zero = 8'(v[2]); d_zero = 8'(v[3]); end
                    default: begin a_pos = 8'(v[0]); b_pos = 8'(v[1]); c_pos = 8'(v[2]); d_pos = 8'(v[3]); end
                endcase
            end
            x = 8'(rnd8());
            @(posedge clk);
            #1;
            check_all_model("rand");
            check("rand_range", int'(mu_neg > 16'h7FFF || mu_zero > 16'h7FFF || mu_pos > 16'h7FFF), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fuzzifier_dt.md
FUZZIFIER_DT -- requirements
Module: fuzzifier_dt

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- x  input  8 signed  crisp dT sample, Q7.0
- a_neg, b_neg, c_neg, d_neg  input  8 signed each  NEG trapezoid breakpoints, Q7.0
- a_zero, b_zero, c_zero, d_zero  input  8 signed each  ZERO trapezoid breakpoints, Q7.0
- a_pos, b_pos, c_pos, d_pos  input  8 signed each  POS trapezoid breakpoints, Q7.0
- mu_neg  output  16  NEG membership, Q1.15, range 0..0x7FFF
- mu_zero  output  16  ZERO membership, Q1.15, range 0..0x7FFF
- mu_pos  output  16  POS membership, Q1.15, range 0..0x7FFF
REQ-003 The block SHALL have no parameters.

Function
REQ-004 Three identical trapezoid membership evaluators SHALL run in parallel, one per set, each using x and its own a, b, c, d.
REQ-005 Each evaluator SHALL apply these rules in priority order (signed compares):
- x<=a or x>=d -> 0
- b<=x<=c -> 0x7FFF
- a<x<b -> floor(((x-a)<<15)/(b-a))
- otherwise -> floor(((d-x)<<15)/(d-c))
REQ-006 Differences SHALL be computed as 9-bit signed values.
REQ-007 The numerator SHALL be the 9-bit difference shifted left by 15, held in 24 bits and treated as unsigned.
REQ-008 The divisor SHALL be the 9-bit difference treated as unsigned; a zero divisor SHALL be replaced by 1.
REQ-009 The quotient SHALL be unsigned integer division truncated to 16 bits, then saturated to 0x7FFF.
REQ-010 Outputs SHALL never exceed 0x7FFF and SHALL never be negative.
REQ-011 Breakpoint ordering a<=b<=c<=d is not required; for unordered breakpoints the REQ-005 priority order and REQ-006..REQ-009 arithmetic SHALL apply unchanged.
REQ-012 Degenerate shapes SHALL follow REQ-005:
- b=c gives a triangle peaking at 0x7FFF.
- a=b or c=d gives a vertical edge.
REQ-013 Timing:
- x and all breakpoints are sampled combinationally.
- The three results SHALL be registered on each rising clk edge, giving 1-cycle latency.
- Outputs SHALL update every cycle, with no handshake.
REQ-014 All three outputs SHALL update on the same edge.

Reset
REQ-015 While rst=1, mu_neg, mu_zero and mu_pos SHALL be 0, asynchronously and independent of clk.
REQ-016 After rst deasserts, the first rising clk edge SHALL load valid results.
REQ-017 Asserting rst mid-operation SHALL clear the outputs immediately; there is no other internal state.

Verification
Defaults used in REQ-018..REQ-020:
- NEG = -100, -50, -30, -5
- ZERO = -10, 0, 0, 10
- POS = 5, 25, 35, 60

REQ-018 Defaults; x=-128, then x=127 -> all outputs 0 one cycle later (x<=a, x>=d).
REQ-019 Defaults; x=0 -> mu_zero=0x7FFF, mu_neg=0, mu_pos=0.
REQ-020 Defaults, rising and falling edges:
- x=-60 -> mu_neg=26214
- x=-5 -> mu_zero=16384, mu_neg=0
- x=16 -> mu_pos=18022
- x=49 -> mu_pos=14417
- x=-38 -> mu_neg=0x7FFF
REQ-021 Set POS a=b=c=d=20; x=20 -> mu_pos=0 (x>=d wins); x=19 -> mu_pos=0.
REQ-022 Assert rst mid-stream with nonzero outputs -> all outputs 0 before the next clk edge; deassert -> correct values after one edge.
REQ-023 Randomized ordered breakpoints and random x over -128..127 -> every output matches the REQ-005..REQ-009 reference model one cycle later and stays <=0x7FFF.
